// File: rtl/if_fetch_unit.sv
// Instruction fetch unit.
//
// Issues word-aligned fetch requests to instruction memory, tracks up to two in-flight
// requests, buffers returned instructions in a two-entry output FIFO and presents them to
// the IF/ID stage. A redirect retargets fetch, flushes the FIFO and marks every request
// still in flight to be dropped when its response returns.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   stall             - IF/ID is not accepting this cycle
//   redirect_valid    - taken branch/jump from a later stage
//   redirect_pc       - new fetch target (bits [1:0] ignored)
//   imem_req_*        - fetch request channel (valid/ready/addr)
//   imem_resp_*       - in-order response channel (valid/data), latency >= 1
//   out_valid/pc/instr- fetched instruction towards IF/ID
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  // Fetch PC
  logic [31:0] fetch_pc_q, fetch_pc_d;

  // In-flight PC queue: head pointer plus outstanding count
  logic [31:0] infl_pc_q [2];
  logic        infl_head_q, infl_head_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  drop_q, drop_d;

  // Output FIFO of {pc, instr}
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];
  logic        fifo_head_q, fifo_head_d;
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;

  logic [2:0]  credit_used;
  logic        req_fire;
  logic        resp_take;
  logic        resp_keep;
  logic        fifo_pop;
  logic        infl_wr_idx;
  logic        fifo_wr_idx;

  // Requests in flight plus buffered instructions never exceed two, so a response always
  // has a FIFO slot waiting for it.
  assign credit_used    = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < 3'd2);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp_take = imem_resp_valid && (outst_q != 2'd0);
  // Responses in a redirect cycle belong to the old path.
  assign resp_keep = resp_take && (drop_q == 2'd0) && !redirect_valid;

  assign out_valid = !rst && (fifo_cnt_q != 2'd0) && !redirect_valid;
  assign fifo_pop  = out_valid && !stall;

  // Tail slot = head + count; a push only happens with count 0 or 1 (queue) or via the
  // full-FIFO push+pop case where the tail slot equals the slot being vacated.
  assign infl_wr_idx = infl_head_q ^ outst_q[0];
  assign fifo_wr_idx = fifo_head_q ^ fifo_cnt_q[0];

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    infl_head_d = infl_head_q ^ resp_take;
    outst_d     = outst_q + {1'b0, req_fire} - {1'b0, resp_take};
    drop_d      = drop_q;
    fifo_head_d = fifo_head_q;
    fifo_cnt_d  = fifo_cnt_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      // Everything still outstanding after this cycle is stale.
      drop_d     = outst_d;
      fifo_cnt_d = 2'd0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (resp_take && (drop_q != 2'd0)) begin
        drop_d = drop_q - 2'd1;
      end
      fifo_head_d = fifo_head_q ^ fifo_pop;
      fifo_cnt_d  = fifo_cnt_q + {1'b0, resp_keep} - {1'b0, fifo_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      infl_head_q <= 1'b0;
      outst_q     <= 2'd0;
      drop_q      <= 2'd0;
      fifo_head_q <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        infl_pc_q[i]    <= 32'd0;
        fifo_pc_q[i]    <= 32'd0;
        fifo_instr_q[i] <= 32'd0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      infl_head_q <= infl_head_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      fifo_head_q <= fifo_head_d;
      fifo_cnt_q  <= fifo_cnt_d;
      if (req_fire) begin
        infl_pc_q[infl_wr_idx] <= fetch_pc_q;
      end
      if (resp_keep) begin
        fifo_pc_q[fifo_wr_idx]    <= infl_pc_q[infl_head_q];
        fifo_instr_q[fifo_wr_idx] <= imem_resp_data;
      end
    end
  end

  always_comb begin
    out_pc    = 32'd0;
    out_instr = NopInstr;
    if (out_valid) begin
      out_pc    = fifo_pc_q[fifo_head_q];
      out_instr = fifo_instr_q[fifo_head_q];
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit. Two instances: u_dut (RESET_PC = 0)
// receives all directed stimulus; u_dut2 (RESET_PC = 0xFFFF_FFF8) free-runs to show
// address wrap. Each instance has a small memory model returning ~addr as instruction.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        mem_ready;
  logic        mem_hold;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  logic        zero_in = 1'b0;
  logic [31:0] zero_pc = 32'd0;
  logic        one_in  = 1'b1;
  logic        req_valid2;
  logic [31:0] req_addr2;
  logic        resp_valid2;
  logic [31:0] resp_data2;
  logic        out_valid2;
  logic [31:0] out_pc2;
  logic [31:0] out_instr2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] pend1 [$];
  logic [31:0] pend2 [$];
  logic [31:0] req_log [$];
  logic [31:0] out_log_pc [$];
  logic [31:0] out_log_in [$];
  logic [31:0] req_log2 [$];
  logic [31:0] out_log2_pc [$];
  logic [31:0] out_log2_in [$];

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (req_valid),
    .imem_req_addr   (req_addr),
    .imem_req_ready  (mem_ready),
    .imem_resp_valid (resp_valid),
    .imem_resp_data  (resp_data),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instr       (out_instr)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
    .clk             (clk),
    .rst             (rst),
    .stall           (zero_in),
    .redirect_valid  (zero_in),
    .redirect_pc     (zero_pc),
    .imem_req_valid  (req_valid2),
    .imem_req_addr   (req_addr2),
    .imem_req_ready  (one_in),
    .imem_resp_valid (resp_valid2),
    .imem_resp_data  (resp_data2),
    .out_valid       (out_valid2),
    .out_pc          (out_pc2),
    .out_instr       (out_instr2)
  );

  // Memory for u_dut: latency 1 unless mem_hold, in-order, data = ~addr.
  always @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
      pend1.delete();
    end else begin
      if (req_valid && mem_ready) begin
        pend1.push_back(req_addr);
        req_log.push_back(req_addr);
      end
      if (!mem_hold && pend1.size() > 0) begin
        resp_valid <= 1'b1;
        resp_data  <= ~pend1.pop_front();
      end else begin
        resp_valid <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      resp_valid2 <= 1'b0;
      resp_data2  <= 32'd0;
      pend2.delete();
    end else begin
      if (req_valid2) begin
        pend2.push_back(req_addr2);
        req_log2.push_back(req_addr2);
      end
      if (pend2.size() > 0) begin
        resp_valid2 <= 1'b1;
        resp_data2  <= ~pend2.pop_front();
      end else begin
        resp_valid2 <= 1'b0;
      end
    end
  end

  // Instructions actually consumed by IF/ID
  always @(posedge clk) begin
    if (out_valid && !stall) begin
      out_log_pc.push_back(out_pc);
      out_log_in.push_back(out_instr);
    end
    if (out_valid2) begin
      out_log2_pc.push_back(out_pc2);
      out_log2_in.push_back(out_instr2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    mem_ready      = 1'b1;
    mem_hold       = 1'b0;
    smp();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'h0000_0013);
    cyc();
    cyc();
    req_log.delete();
    out_log_pc.delete();
    out_log_in.delete();
    req_log2.delete();
    out_log2_pc.delete();
    out_log2_in.delete();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- Streaming from reset, then 5-cycle stall ----------------
    do_reset();
    smp();  // c0
    chk("a0_req_valid", 32'(req_valid), 32'd1);
    chk("a0_req_addr", req_addr, 32'h0);
    chk("a0_out_valid", 32'(out_valid), 32'd0);
    cyc();
    smp();  // c1: response for 0x0 arrives, not yet visible
    chk("a1_req_addr", req_addr, 32'h4);
    chk("a1_out_valid", 32'(out_valid), 32'd0);
    cyc();
    smp();  // c2
    chk("a2_req_valid", 32'(req_valid), 32'd0);
    chk("a2_out_valid", 32'(out_valid), 32'd1);
    chk("a2_out_pc", out_pc, 32'h0);
    chk("a2_out_instr", out_instr, 32'hFFFF_FFFF);
    cyc();
    smp();  // c3
    chk("a3_req_addr", req_addr, 32'h8);
    chk("a3_out_pc", out_pc, 32'h4);
    chk("a3_out_instr", out_instr, 32'hFFFF_FFFB);
    cyc();
    smp();  // c4
    chk("a4_out_valid", 32'(out_valid), 32'd0);
    chk("a4_req_addr", req_addr, 32'hC);
    cyc();
    smp();  // c5
    chk("a5_out_pc", out_pc, 32'h8);
    cyc();
    stall = 1'b1;
    smp();  // c6
    chk("a6_out_pc", out_pc, 32'hC);
    chk("a6_req_valid", 32'(req_valid), 32'd1);
    chk("a6_req_addr", req_addr, 32'h10);
    cyc();
    for (int k = 7; k <= 10; k++) begin
      smp();
      chk("stall_req_valid", 32'(req_valid), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_pc", out_pc, 32'hC);
      chk("stall_out_instr", out_instr, 32'hFFFF_FFF3);
      cyc();
    end
    stall = 1'b0;
    smp();  // c11
    chk("a11_out_pc", out_pc, 32'hC);
    chk("a11_req_valid", 32'(req_valid), 32'd0);
    cyc();
    smp();  // c12
    chk("a12_out_pc", out_pc, 32'h10);
    chk("a12_req_addr", req_addr, 32'h14);
    cyc();
    smp();  // c13
    chk("a13_out_valid", 32'(out_valid), 32'd0);
    chk("a13_req_addr", req_addr, 32'h18);
    cyc();
    smp();  // c14
    chk("a14_out_pc", out_pc, 32'h14);
    chk("a14_req_valid", 32'(req_valid), 32'd0);
    cyc();
    smp();  // c15
    chk("a15_out_pc", out_pc, 32'h18);
    chk("a15_req_addr", req_addr, 32'h1C);
    cyc();
    chk("a_req_log_size", 32'(req_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("a_req_log", (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF, 32'(4 * i));
    end
    chk("a_out_log_size", 32'(out_log_pc.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      chk("a_out_log_pc", (i < out_log_pc.size()) ? out_log_pc[i] : 32'hDEAD_BEEF,
          32'(4 * i));
      chk("a_out_log_instr", (i < out_log_in.size()) ? out_log_in[i] : 32'hDEAD_BEEF,
          ~32'(4 * i));
    end
    // Wrapping instance
    chk("w_req0", (req_log2.size() > 0) ? req_log2[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    chk("w_req1", (req_log2.size() > 1) ? req_log2[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("w_req2", (req_log2.size() > 2) ? req_log2[2] : 32'hDEAD_BEEF, 32'h0000_0000);
    chk("w_out_pc0", (out_log2_pc.size() > 0) ? out_log2_pc[0] : 32'hDEAD_BEEF,
        32'hFFFF_FFF8);
    chk("w_out_in0", (out_log2_in.size() > 0) ? out_log2_in[0] : 32'hDEAD_BEEF,
        32'h0000_0007);

    // ---------------- Redirect with two requests outstanding ----------------
    do_reset();
    mem_hold = 1'b1;
    smp();  // c0
    chk("r0_req_addr", req_addr, 32'h0);
    cyc();
    smp();  // c1
    chk("r1_req_addr", req_addr, 32'h4);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    smp();  // c2
    chk("r2_req_valid", 32'(req_valid), 32'd0);
    chk("r2_out_valid", 32'(out_valid), 32'd0);
    chk("r2_out_instr", out_instr, 32'h0000_0013);
    cyc();
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    smp();  // c3
    chk("r3_req_valid", 32'(req_valid), 32'd0);
    cyc();
    smp();  // c4: stale response for 0x0
    chk("r4_req_valid", 32'(req_valid), 32'd0);
    chk("r4_out_valid", 32'(out_valid), 32'd0);
    cyc();
    smp();  // c5: stale response for 0x4
    chk("r5_req_valid", 32'(req_valid), 32'd1);
    chk("r5_req_addr", req_addr, 32'h100);
    chk("r5_out_valid", 32'(out_valid), 32'd0);
    cyc();
    smp();  // c6
    chk("r6_out_valid", 32'(out_valid), 32'd0);
    chk("r6_req_addr", req_addr, 32'h104);
    cyc();
    smp();  // c7
    chk("r7_out_valid", 32'(out_valid), 32'd1);
    chk("r7_out_pc", out_pc, 32'h100);
    chk("r7_out_instr", out_instr, 32'hFFFF_FEFF);
    cyc();
    chk("r_out_log_size", 32'(out_log_pc.size()), 32'd1);
    chk("r_req_log2", (req_log.size() > 2) ? req_log[2] : 32'hDEAD_BEEF, 32'h100);

    // ---------------- Response in the redirect cycle is discarded ----------------
    do_reset();
    smp();  // c0
    chk("d0_req_addr", req_addr, 32'h0);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    smp();  // c1: response for 0x0 arrives here
    chk("d1_req_valid", 32'(req_valid), 32'd0);
    cyc();
    redirect_valid = 1'b0;
    smp();  // c2
    chk("d2_out_valid", 32'(out_valid), 32'd0);
    chk("d2_req_addr", req_addr, 32'h40);
    cyc();
    smp();  // c3
    chk("d3_out_valid", 32'(out_valid), 32'd0);
    cyc();
    smp();  // c4
    chk("d4_out_pc", out_pc, 32'h40);
    chk("d4_out_instr", out_instr, 32'hFFFF_FFBF);
    cyc();

    // ---------------- Memory not ready for 3 cycles ----------------
    do_reset();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("nr_req_valid", 32'(req_valid), 32'd1);
      chk("nr_req_addr", req_addr, 32'h0);
      cyc();
    end
    mem_ready = 1'b1;
    smp();
    chk("nr3_req_addr", req_addr, 32'h0);
    cyc();
    smp();
    chk("nr4_req_addr", req_addr, 32'h4);
    chk("nr_log_size", 32'(req_log.size()), 32'd1);
    cyc();

    // ---------------- Redirect during stall with full FIFO ----------------
    do_reset();
    stall = 1'b1;
    smp();
    cyc();
    smp();
    cyc();
    smp();  // c2
    chk("g2_out_pc", out_pc, 32'h0);
    chk("g2_req_valid", 32'(req_valid), 32'd0);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0206;
    smp();  // c3
    chk("g3_out_valid", 32'(out_valid), 32'd0);
    chk("g3_req_valid", 32'(req_valid), 32'd0);
    cyc();
    redirect_valid = 1'b0;
    smp();  // c4
    chk("g4_out_valid", 32'(out_valid), 32'd0);
    chk("g4_req_valid", 32'(req_valid), 32'd1);
    chk("g4_req_addr", req_addr, 32'h204);
    cyc();
    smp();  // c5
    chk("g5_out_valid", 32'(out_valid), 32'd0);
    cyc();
    smp();  // c6
    chk("g6_out_valid", 32'(out_valid), 32'd1);
    chk("g6_out_pc", out_pc, 32'h204);
    chk("g6_out_instr", out_instr, 32'hFFFF_FDFB);
    cyc();

    // ---------------- Reset with a full FIFO ----------------
    do_reset();
    stall = 1'b1;
    smp();
    cyc();
    smp();
    cyc();
    smp();
    cyc();
    rst = 1'b1;
    smp();  // c3
    chk("f3_req_valid", 32'(req_valid), 32'd0);
    chk("f3_out_valid", 32'(out_valid), 32'd0);
    chk("f3_out_pc", out_pc, 32'h0);
    chk("f3_out_instr", out_instr, 32'h0000_0013);
    cyc();
    rst = 1'b0;
    smp();  // c4
    chk("f4_out_valid", 32'(out_valid), 32'd0);
    chk("f4_out_instr", out_instr, 32'h0000_0013);
    chk("f4_req_valid", 32'(req_valid), 32'd1);
    chk("f4_req_addr", req_addr, 32'h0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
